// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the handshaked data memory.
// RV32I funct3 codes, FSM states and access legality checks.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] lo
  );
    case (funct3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Stores have no unsigned variants.
  function automatic logic f3_legal(
    input logic [2:0] funct3,
    input logic       we
  );
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_hs_load_align.sv
// Load lane extraction: picks the addressed byte or halfword
// from a memory word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[8*lane_i +: 8];
    h = lane_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = '0;
    unique case (1'b1)
      (funct3_i == F3_B):  data_o = {{24{b[7]}}, b};
      (funct3_i == F3_H):  data_o = {{16{h[15]}}, h};
      (funct3_i == F3_W):  data_o = word_i;
      (funct3_i == F3_BU): data_o = {24'h0, b};
      (funct3_i == F3_HU): data_o = {16'h0, h};
      default:             data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressable RV32I data memory with valid/ready request
// handshake, configurable response latency and error reporting.
module data_mem_hs
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic        rsp_err_q;
  logic [31:0] res_q;
  logic [31:0] rdata_q;

  logic          accept;
  logic          oor;
  logic          err_d;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [31:0]   aligned;
  logic [31:0]   res_d;
  logic [31:0]   wdat;
  logic [3:0]    be;

  assign accept = req_valid && ready_q;
  assign idx    = req_addr[AW+1:2];
  assign lane   = req_addr[1:0];
  assign oor    = (req_addr >> (AW + 2)) != '0;
  assign err_d  = oor
               || is_misaligned(req_funct3, lane)
               || !f3_legal(req_funct3, req_we);
  assign word   = mem[idx];
  assign wr_en  = accept && req_we && !err_d;
  assign res_d  = (err_d || req_we) ? 32'h0 : aligned;

  dmem_load_align u_align (
    .word_i   (word),
    .lane_i   (lane),
    .funct3_i (req_funct3),
    .data_o   (aligned)
  );

  always_comb begin
    be   = '0;
    wdat = req_wdata;
    unique case (1'b1)
      (req_funct3 == F3_B): begin
        be   = 4'b0001 << lane;
        wdat = {4{req_wdata[7:0]}};
      end
      (req_funct3 == F3_H): begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{req_wdata[15:0]}};
      end
      (req_funct3 == F3_W): be = 4'hf;
      default: be = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  // Load data is extracted at accept so later stores cannot alter it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q   <= S_RESP;
              valid_q   <= 1'b1;
              rdata_q   <= res_d;
              rsp_err_q <= err_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_M1;
              res_q   <= res_d;
              err_q   <= err_d;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd1) begin
            state_q   <= S_RESP;
            cnt_q     <= '0;
            valid_q   <= 1'b1;
            rdata_q   <= res_q;
            rsp_err_q <= err_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs at latencies 1, 4 and 3.
// Expected values are hand-computed constants.
module tb_data_mem_hs;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = '0;
  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [2:0]  er;
  logic [31:0] rd [3];
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = W;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_mem_hs #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(req_we), .req_funct3(req_f3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .rsp_err(er[0])
  );

  data_mem_hs #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(req_we), .req_funct3(req_f3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .rsp_err(er[1])
  );

  data_mem_hs #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(req_we), .req_funct3(req_f3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
    .rsp_err(er[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic txn(input int d, input int lat, input logic we,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rdata,
                     output logic err);
    int n;
    @(negedge clk);
    chk("ready", 32'(rdy[d]), 1);
    vld[d] = 1'b1;
    req_we = we;
    req_f3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1 vld[d] = 1'b0;
    n = 0;
    while (!rv[d] && n < 12) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 32'(n), 32'(lat - 1));
    chk("rsp_valid", 32'(rv[d]), 1);
    rdata = rd[d];
    err = er[d];
    @(posedge clk);
    #1 chk("one_pulse", 32'(rv[d]), 0);
  endtask

  task automatic st(input int d, input int lat, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r;
    logic e;
    txn(d, lat, 1'b1, f3, a, wd, r, e);
    chk("st_err", 32'(e), 0);
    chk("st_rdata", r, 0);
  endtask

  task automatic ld(input int d, input int lat, input string tag,
                    input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    txn(d, lat, 1'b0, f3, a, 32'h0, r, e);
    chk(tag, r, exp);
    chk({tag, "_err"}, 32'(e), 0);
  endtask

  task automatic bad_req(input string tag, input logic we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    logic [31:0] r;
    logic e;
    txn(0, 1, we, f3, a, wd, r, e);
    chk({tag, "_err"}, 32'(e), 1);
    chk({tag, "_rdata"}, r, 0);
  endtask

  initial begin
    int acc, rsps, busy, last, cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(rdy), 32'h7);
    chk("rst_valid", 32'(rv), 0);
    chk("rst_rdata", rd[0], 0);
    chk("rst_err", 32'(er), 0);

    st(0, 1, W, 32'h10, 32'hDEADBEEF);
    ld(0, 1, "lw10", W, 32'h10, 32'hDEADBEEF);
    chk("hold_rdata", rd[0], 32'hDEADBEEF);
    st(0, 1, B, 32'h13, 32'h1234565A);
    ld(0, 1, "lw_sb13", W, 32'h10, 32'h5AADBEEF);
    ld(0, 1, "lb13", B, 32'h13, 32'h0000005A);
    ld(0, 1, "lbu13", BU, 32'h13, 32'h0000005A);
    st(0, 1, B, 32'h11, 32'h00000080);
    ld(0, 1, "lb11", B, 32'h11, 32'hFFFFFF80);
    ld(0, 1, "lbu11", BU, 32'h11, 32'h00000080);
    ld(0, 1, "lw_sb11", W, 32'h10, 32'h5AAD80EF);

    st(0, 1, W, 32'h20, 32'h11223344);
    st(0, 1, H, 32'h22, 32'hABCD8001);
    ld(0, 1, "lh22", H, 32'h22, 32'hFFFF8001);
    ld(0, 1, "lhu22", HU, 32'h22, 32'h00008001);
    ld(0, 1, "lw_sh22", W, 32'h20, 32'h80013344);

    st(0, 1, W, 32'h0, 32'h01020304);
    bad_req("lw12", 1'b0, W, 32'h12, 32'h0);
    bad_req("sh21", 1'b1, H, 32'h21, 32'h0000FFFF);
    bad_req("lw400", 1'b0, W, 32'h400, 32'h0);
    bad_req("sw400", 1'b1, W, 32'h400, 32'hFFFFFFFF);
    bad_req("sbu20", 1'b1, BU, 32'h20, 32'h0);
    bad_req("f3_011", 1'b0, 3'b011, 32'h20, 32'h0);
    ld(0, 1, "lw20_kept", W, 32'h20, 32'h80013344);
    ld(0, 1, "lw0_kept", W, 32'h0, 32'h01020304);

    // Latency 4 with valid held high for 25 cycles.
    @(negedge clk);
    req_we = 1'b0;
    req_f3 = W;
    req_addr = 32'h0;
    vld[1] = 1'b1;
    acc = 0;
    rsps = 0;
    busy = 0;
    last = -5;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clk);
      if (rdy[1]) begin
        if (acc > 0) chk("acc_gap", 32'(c - last), 5);
        acc++;
        last = c;
      end else begin
        busy++;
      end
      if (rv[1]) rsps++;
    end
    vld[1] = 1'b0;
    chk("l4_accepts", 32'(acc), 5);
    chk("l4_rsps", 32'(rsps), 5);
    chk("l4_busy", 32'(busy), 20);

    // Latency 3: abort a load with an asynchronous reset.
    st(2, 3, W, 32'h8, 32'hCAFEF00D);
    @(negedge clk);
    req_we = 1'b0;
    req_f3 = W;
    req_addr = 32'h8;
    vld[2] = 1'b1;
    @(posedge clk);
    #1 vld[2] = 1'b0;
    @(posedge clk);
    #1 chk("l3_busy", 32'(rdy[2]), 0);
    rst = 1'b1;
    #1 chk("l3_async_ready", 32'(rdy[2]), 1);
    chk("l3_no_valid", 32'(rv[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (rv[2]) cnt++;
    end
    chk("l3_aborted", 32'(cnt), 0);
    ld(2, 3, "l3_lw8", W, 32'h8, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
